// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } hazState_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BRANCH = 2'd1,
    CAUSE_JUMP   = 2'd2
  } flushCause_t;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic pipeFreeze;
  } hazCtrl_t;

  localparam hazCtrl_t CTRL_RUN = '{pcWrite: 1'b1, ifidWrite: 1'b1, default: 1'b0};

  // A load in ID/EX whose destination feeds the instruction in IF/ID; r0 never counts.
  function automatic logic isLoadUse(input logic memRead, input logic [REG_W-1:0] exRt,
                                     input logic [REG_W-1:0] ifRs, input logic [REG_W-1:0] ifRt);
    return memRead && (exRt != REG_ZERO) && ((exRt == ifRs) || (exRt == ifRt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and memory freezes,
// with registered controls, saturating event counters and a sticky freeze-overrun flag.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FREEZE_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             idex_jump,
  input  logic             exmem_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             freeze_timeout
);

  localparam int unsigned LIMIT_W = $clog2(FREEZE_LIMIT + 1);
  localparam int unsigned FRZ_W   = (LIMIT_W > 9) ? LIMIT_W : 9;
  localparam logic [FRZ_W-1:0] FRZ_LIMIT = FRZ_W'(FREEZE_LIMIT);

  hazState_t       state;
  hazState_t       nextState;
  flushCause_t     nextCause;
  hazCtrl_t        ctrl;
  hazCtrl_t        ctrlNext;
  logic [FRZ_W-1:0] runCnt;
  logic [FRZ_W-1:0] runCntNext;
  logic            loadUse;
  logic            stallInc;
  logic            flushInc;

  assign loadUse = isLoadUse(idex_memread, idex_rt, ifid_rs, ifid_rt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Every state re-evaluates from the current inputs; nothing seen during a freeze is kept.
  always_comb begin
    nextState = RUN;
    nextCause = CAUSE_NONE;
    if (mem_busy) begin
      nextState = FREEZE;
    end else if (exmem_branch_taken) begin
      nextState = FLUSH;
      nextCause = CAUSE_BRANCH;
    end else if (idex_jump) begin
      nextState = FLUSH;
      nextCause = CAUSE_JUMP;
    end else if (loadUse) begin
      nextState = LSTALL;
    end
  end

  // Controls for the state being entered, captured on the same edge as the state.
  always_comb begin
    ctrlNext = CTRL_RUN;
    unique case (nextState)
      LSTALL: begin
        ctrlNext.pcWrite   = 1'b0;
        ctrlNext.ifidWrite = 1'b0;
        ctrlNext.idexFlush = 1'b1;
      end
      FLUSH: begin
        ctrlNext.ifidFlush  = 1'b1;
        ctrlNext.idexFlush  = 1'b1;
        ctrlNext.exmemFlush = (nextCause == CAUSE_BRANCH);
      end
      FREEZE: begin
        ctrlNext.pcWrite    = 1'b0;
        ctrlNext.ifidWrite  = 1'b0;
        ctrlNext.pipeFreeze = 1'b1;
      end
      default: ctrlNext = CTRL_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= CTRL_RUN;
    end else begin
      ctrl <= ctrlNext;
    end
  end

  // Freeze run length: restarts at one on entry, holds at all-ones, clears on exit.
  always_comb begin
    runCntNext = '0;
    if (nextState == FREEZE) begin
      if (state != FREEZE) begin
        runCntNext = FRZ_W'(1);
      end else if (runCnt == {FRZ_W{1'b1}}) begin
        runCntNext = runCnt;
      end else begin
        runCntNext = runCnt + FRZ_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runCnt         <= '0;
      freeze_timeout <= 1'b0;
    end else begin
      runCnt <= runCntNext;
      if ((nextState == FREEZE) && (runCntNext >= FRZ_LIMIT)) begin
        freeze_timeout <= 1'b1;
      end
    end
  end

  assign stallInc = (nextState == LSTALL);
  assign flushInc = (nextState == FLUSH);

  sat_counter #(.WIDTH(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stallInc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flushInc),
    .count (flush_cnt)
  );

  assign pc_write    = ctrl.pcWrite;
  assign ifid_write  = ctrl.ifidWrite;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_flush  = ctrl.idexFlush;
  assign exmem_flush = ctrl.exmemFlush;
  assign pipe_freeze = ctrl.pipeFreeze;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic
// compared cycle by cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W        = 4;
  localparam int unsigned FREEZE_LIMIT = 255;
  localparam int          CNT_MAX      = (1 << CNT_W) - 1;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze}
  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_BRANCH = 6'b111110;
  localparam logic [5:0] C_JUMP   = 6'b111100;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       ifid_rs = '0;
  logic [4:0]       ifid_rt = '0;
  logic             idex_memread = 1'b0;
  logic [4:0]       idex_rt = '0;
  logic             idex_jump = 1'b0;
  logic             exmem_branch_taken = 1'b0;
  logic             mem_busy = 1'b0;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             freeze_timeout;

  int         numTests = 0;
  int         numFails = 0;
  logic [5:0] expCtrl;
  int         expStall;
  int         expFlush;
  int         freezeRun;
  logic       expTimeout;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .FREEZE_LIMIT(FREEZE_LIMIT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifid_rs            (ifid_rs),
    .ifid_rt            (ifid_rt),
    .idex_memread       (idex_memread),
    .idex_rt            (idex_rt),
    .idex_jump          (idex_jump),
    .exmem_branch_taken (exmem_branch_taken),
    .mem_busy           (mem_busy),
    .pc_write           (pc_write),
    .ifid_write         (ifid_write),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .exmem_flush        (exmem_flush),
    .pipe_freeze        (pipe_freeze),
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt),
    .freeze_timeout     (freeze_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numTests++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    expCtrl    = C_RUN;
    expStall   = 0;
    expFlush   = 0;
    freezeRun  = 0;
    expTimeout = 1'b0;
  endtask

  // Applies the priority rules to the inputs seen at a rising edge.
  task automatic modelStep();
    bit lu;
    lu = idex_memread && (idex_rt != 5'd0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    if (mem_busy) begin
      expCtrl = C_FREEZE;
      freezeRun++;
      if (freezeRun >= FREEZE_LIMIT) expTimeout = 1'b1;
    end else begin
      freezeRun = 0;
      if (exmem_branch_taken) begin
        expCtrl = C_BRANCH;
        if (expFlush < CNT_MAX) expFlush++;
      end else if (idex_jump) begin
        expCtrl = C_JUMP;
        if (expFlush < CNT_MAX) expFlush++;
      end else if (lu) begin
        expCtrl = C_STALL;
        if (expStall < CNT_MAX) expStall++;
      end else begin
        expCtrl = C_RUN;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkEq({tag, "_ctrl"}, 32'({pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_freeze}),
            32'(expCtrl));
    checkEq({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(expStall));
    checkEq({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(expFlush));
    checkEq({tag, "_timeout"}, 32'(freeze_timeout), 32'(expTimeout));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic setIdle();
    ifid_rs            = '0;
    ifid_rt            = '0;
    idex_memread       = 1'b0;
    idex_rt            = '0;
    idex_jump          = 1'b0;
    exmem_branch_taken = 1'b0;
    mem_busy           = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    // r0 as load destination never stalls
    setIdle();
    idex_memread = 1'b1;
    cycle("zero_reg");
    checkEq("zero_reg_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load-use: one stall cycle, then back to RUN
    setIdle();
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    cycle("load_use");
    checkEq("load_use_pc_write", 32'(pc_write), 32'd0);
    checkEq("load_use_stall_cnt", 32'(stall_cnt), 32'd1);
    setIdle();
    cycle("load_use_after");
    checkEq("load_use_run_pc_write", 32'(pc_write), 32'd1);

    // Back-to-back load-use stalls again
    idex_memread = 1'b1; idex_rt = 5'd7; ifid_rt = 5'd7;
    cycle("stall_a");
    cycle("stall_b");
    checkEq("stall_repeat_cnt", 32'(stall_cnt), 32'd3);

    // Branch wins over load-use
    exmem_branch_taken = 1'b1;
    cycle("branch_lu");
    checkEq("branch_lu_exmem_flush", 32'(exmem_flush), 32'd1);
    checkEq("branch_lu_flush_cnt", 32'(flush_cnt), 32'd1);
    checkEq("branch_lu_stall_cnt", 32'(stall_cnt), 32'd3);

    setIdle();
    idex_jump = 1'b1;
    cycle("jump");
    checkEq("jump_exmem_flush", 32'(exmem_flush), 32'd0);
    checkEq("jump_idex_flush", 32'(idex_flush), 32'd1);
    setIdle();
    cycle("jump_after");

    // Freeze overrun
    mem_busy = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      cycle("freeze");
      if (i == 254) checkEq("timeout_at_254", 32'(freeze_timeout), 32'd0);
      if (i == 255) checkEq("timeout_at_255", 32'(freeze_timeout), 32'd1);
    end
    mem_busy = 1'b0;
    cycle("freeze_release");
    checkEq("timeout_sticky", 32'(freeze_timeout), 32'd1);

    // Reset mid-freeze takes effect without a clock edge
    mem_busy = 1'b1;
    repeat (3) cycle("pre_rst_freeze");
    #1 rst_n = 1'b0;
    #1 modelReset();
    checkAll("rst_mid_freeze");
    @(negedge clk);
    setIdle();
    rst_n = 1'b1;
    cycle("post_rst_freeze");

    // Reset mid-flush
    exmem_branch_taken = 1'b1;
    cycle("pre_rst_flush");
    #1 rst_n = 1'b0;
    #1 modelReset();
    checkAll("rst_mid_flush");
    @(negedge clk);
    setIdle();
    rst_n = 1'b1;
    cycle("post_rst_flush");

    // Random traffic; narrow register range keeps matches and r0 frequent
    for (int n = 0; n < 1500; n++) begin
      ifid_rs            = 5'($urandom_range(0, 3));
      ifid_rt            = 5'($urandom_range(0, 3));
      idex_rt            = 5'($urandom_range(0, 3));
      idex_memread       = ($urandom_range(0, 1) == 1);
      idex_jump          = ($urandom_range(0, 7) == 0);
      exmem_branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy           = ($urandom_range(0, 9) == 0);
      cycle("random");
    end
    checkEq("stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));
    checkEq("flush_saturated", 32'(flush_cnt), 32'(CNT_MAX));

    $display("[TB] %0d tests run, %0d failed", numTests, numFails);
    $finish;
  end

endmodule
